branch_pht: RTL and testbench

Gshare-style branch direction predictor for the five-stage MIPS core. Fetch issues a lookup with the branch PC and receives a registered taken/not-taken prediction plus the table index one cycle later. Execute returns the resolved outcome, produced by the ALU `zero` flag and branch type, together with the carried index. The block trains a 2-bit saturating counter and a global history register, flags mispredictions, and keeps hit/miss statistics for lab reporting.

---
 rtl/bp_pkg.sv | 13 +
 rtl/bp_sat_ctr.sv | 21 ++
 rtl/branch_pht.sv | 88 ++++++++
 tb/tb_branch_pht.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch direction predictor.
// The 2-bit saturating counter's encoding lives here so the table and its trainer agree on it.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT      = 2'b00;
  localparam ctr_t WNT      = 2'b01;
  localparam ctr_t WT       = 2'b10;
  localparam ctr_t ST       = 2'b11;
  localparam ctr_t PHT_INIT = WNT;

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating counter trainer: taken counts up to ST, not-taken counts down to SNT.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  ctr_t cnt,
  input  logic taken,
  output ctr_t cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken && (cnt != ST)) begin
      cnt_next = cnt + 2'd1;
    end else if (!taken && (cnt != SNT)) begin
      cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_pht.sv
// Gshare predictor: PC xor global history indexes a table of 2-bit counters, trained at resolution.
// Latency: lookup result registered 1 cycle later; update writes at its edge, same-cycle lookup is bypassed.
// Backpressure: none, one lookup and one update may be accepted every cycle.
module branch_pht
  import bp_pkg::*;
#(
  parameter int IDX_W  = 10,
  parameter int HIST_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic [31:0]      pred_pc,
  output logic             pred_out_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_index,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic             mispredict,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_misses
);

  localparam int DEPTH = 2 ** IDX_W;

  ctr_t              pht [DEPTH];
  logic [HIST_W-1:0] ghr;
  logic [IDX_W-1:0]  lk_idx;
  ctr_t              upd_cnt_next;
  logic              bypass;
  logic              unused_pc;

  // History is zero-extended into the low index bits; the lookup always sees pre-update history.
  assign lk_idx    = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr);
  assign unused_pc = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

  assign mispredict = upd_valid & (upd_taken != upd_pred);
  assign bypass     = upd_valid & (upd_index == lk_idx);

  bp_sat_ctr u_sat_ctr (
    .cnt      (pht[upd_index]),
    .taken    (upd_taken),
    .cnt_next (upd_cnt_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pht[i] <= PHT_INIT;
      end
      ghr <= '0;
    end else if (upd_valid) begin
      pht[upd_index] <= upd_cnt_next;
      ghr            <= {ghr[HIST_W-2:0], upd_taken};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
      pred_index     <= '0;
    end else begin
      pred_out_valid <= pred_valid;
      if (pred_valid) begin
        pred_index <= lk_idx;
        pred_taken <= bypass ? upd_cnt_next[1] : pht[lk_idx][1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches <= '0;
      stat_misses   <= '0;
    end else begin
      if (upd_valid) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (mispredict) begin
        stat_misses <= stat_misses + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_pht.sv
// Bench for branch_pht: directed scenarios plus randomized traffic against an array-based reference model.
module tb_branch_pht;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_out_valid;
  logic        pred_taken;
  logic [9:0]  pred_index;
  logic        upd_valid;
  logic [9:0]  upd_index;
  logic        upd_taken;
  logic        upd_pred;
  logic        mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_misses;

  int checks = 0;
  int errors = 0;

  // Reference model state: counters as plain integers 0..3, history as an integer.
  int          pht_m [1024];
  int          ghr_m;
  logic [31:0] br_m;
  logic [31:0] miss_m;

  branch_pht #(.IDX_W(10), .HIST_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_out_valid (pred_out_valid),
    .pred_taken     (pred_taken),
    .pred_index     (pred_index),
    .upd_valid      (upd_valid),
    .upd_index      (upd_index),
    .upd_taken      (upd_taken),
    .upd_pred       (upd_pred),
    .mispredict     (mispredict),
    .stat_branches  (stat_branches),
    .stat_misses    (stat_misses)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) pht_m[i] = 1;
    ghr_m  = 0;
    br_m   = '0;
    miss_m = '0;
  endtask

  function automatic int lookup_idx(input logic [31:0] pc);
    return ((int'(pc) >> 2) ^ ghr_m) % 1024;
  endfunction

  // One clock of traffic, entered and left just after a falling edge.
  task automatic cycle(input logic pv, input logic [31:0] pc, input logic uv,
                       input logic [9:0] ui, input logic ut, input logic up);
    int  lk, newc;
    logic exp_tk;
    pred_valid = pv; pred_pc = pc;
    upd_valid = uv; upd_index = ui; upd_taken = ut; upd_pred = up;
    #1;
    chk("mispredict", {31'd0, mispredict}, {31'd0, uv && (ut != up)});
    lk   = lookup_idx(pc);
    newc = 0;
    if (uv) newc = ut ? ((pht_m[ui] == 3) ? 3 : pht_m[ui] + 1)
                      : ((pht_m[ui] == 0) ? 0 : pht_m[ui] - 1);
    exp_tk = (uv && int'(ui) == lk) ? (newc >= 2) : (pht_m[lk] >= 2);
    if (uv) begin
      pht_m[ui] = newc;
      ghr_m     = ((ghr_m << 1) | int'(ut)) % 256;
      br_m++;
      if (ut != up) miss_m++;
    end
    @(posedge clk);
    #1;
    chk("pred_out_valid", {31'd0, pred_out_valid}, {31'd0, pv});
    if (pv) begin
      chk("pred_index", {22'd0, pred_index}, lk);
      chk("pred_taken", {31'd0, pred_taken}, {31'd0, exp_tk});
    end
    chk("stat_branches", stat_branches, br_m);
    chk("stat_misses", stat_misses, miss_m);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 32'd0, 1'b0, 10'd0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    pred_valid = 1'b0; upd_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, pred_out_valid}, 32'd0);
    chk("rst_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_index", {22'd0, pred_index}, 32'd0);
    chk("rst_branches", stat_branches, 32'd0);
    chk("rst_misses", stat_misses, 32'd0);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    int ov_count;
    int pcs;
    logic [9:0] ui;
    logic [31:0] pc;
    rst = 1'b1;
    pred_valid = 1'b0; pred_pc = '0;
    upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0; upd_pred = 1'b0;
    model_reset();
    #3;
    chk("init_out_valid", {31'd0, pred_out_valid}, 32'd0);
    chk("init_branches", stat_branches, 32'd0);
    #9 rst = 1'b0;
    @(negedge clk);

    // Randomized traffic concentrated on a small PC window so counters get trained and revisited.
    for (int n = 0; n < 400; n++) begin
      pcs = $urandom_range(0, 63);
      pc  = {20'h00400, 10'(pcs), 2'($urandom_range(0, 3))};
      ui  = ($urandom_range(0, 3) == 0) ? 10'(lookup_idx(pc)) : 10'($urandom_range(0, 63));
      cycle(1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 2) != 0), ui,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
    end

    // Reset mid-run, then defaults.
    cycle(1'b1, 32'h0040_0010, 1'b1, 10'd3, 1'b1, 1'b0);
    pulse_reset();
    cycle(1'b1, 32'h0040_0000, 1'b0, 10'd0, 1'b0, 1'b0);
    chk("dflt_index", {22'd0, pred_index}, 32'h000);
    chk("dflt_taken", {31'd0, pred_taken}, 32'd0);

    // Training to taken at index 0; history then steers the same PC to index 7.
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'd0, 1'b1, 10'h000, 1'b1, 1'b0);
    chk("train_misses", stat_misses, 32'd3);
    cycle(1'b1, 32'h0040_0000, 1'b0, 10'd0, 1'b0, 1'b0);
    chk("hist_index", {22'd0, pred_index}, 32'h007);
    chk("hist_taken", {31'd0, pred_taken}, 32'd0);
    cycle(1'b1, 32'h0040_001C, 1'b0, 10'd0, 1'b0, 1'b0);
    chk("trained_index", {22'd0, pred_index}, 32'h000);
    chk("trained_taken", {31'd0, pred_taken}, 32'd1);

    // Saturation at strong-NT on index 5, probed after the second decrement and at the end.
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 32'd0, 1'b1, 10'h005, 1'b0, 1'b0);
      if (k == 1) cycle(1'b1, 32'h0000_0014, 1'b0, 10'd0, 1'b0, 1'b0);
    end
    chk("sat_branches", stat_branches, 32'd5);
    cycle(1'b1, 32'h0000_0014, 1'b0, 10'd0, 1'b0, 1'b0);
    chk("sat_taken", {31'd0, pred_taken}, 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 10'h005, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0014 ^ 32'(ghr_m << 2), 1'b0, 10'd0, 1'b0, 1'b0);
    chk("sat_up_taken", {31'd0, pred_taken}, 32'd0);

    // Same-cycle lookup and taken update on an untouched weak-NT counter.
    cycle(1'b1, 32'((9 ^ ghr_m) << 2), 1'b1, 10'd9, 1'b1, 1'b0);
    chk("bypass_index", {22'd0, pred_index}, 32'd9);
    chk("bypass_taken", {31'd0, pred_taken}, 32'd1);

    // Statistics wrap.
    force dut.stat_misses = 32'hFFFF_FFFF;
    #1 release dut.stat_misses;
    #1;
    miss_m = 32'hFFFF_FFFF;
    cycle(1'b0, 32'd0, 1'b1, 10'd20, 1'b0, 1'b1);
    chk("wrap_misses", stat_misses, 32'd0);

    // Back-to-back lookups followed by idle cycles.
    ov_count = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 32'h0040_0000 + 32'(k * 4), 1'b0, 10'd0, 1'b0, 1'b0);
      ov_count += int'(pred_out_valid);
    end
    for (int k = 0; k < 3; k++) begin
      idle();
      ov_count += int'(pred_out_valid);
    end
    chk("b2b_count", ov_count, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
